// File: rtl/bsg_fpu_cmp_pipe.sv
// bsg_fpu_cmp_pipe: two-stage IEEE-754 compare / min / max unit.
// Stage 1 holds the accepted {op, a, b}. Stage 2 holds the registered {result, invalid}.
// A sticky invalid flag accumulates over every result the consumer takes.
module bsg_fpu_cmp_pipe #(
  parameter int e_p = 8,
  parameter int m_p = 23
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [2:0]         op_i,
  input  logic [e_p+m_p:0]   a_i,
  input  logic [e_p+m_p:0]   b_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [e_p+m_p:0]   data_o,
  output logic               invalid_o,
  output logic               invalid_sticky_o,
  input  logic               clear_i
);

  localparam int w = e_p + m_p + 1;

  localparam logic [2:0] op_eq  = 3'd0;
  localparam logic [2:0] op_lt  = 3'd1;
  localparam logic [2:0] op_le  = 3'd2;
  localparam logic [2:0] op_min = 3'd3;
  localparam logic [2:0] op_max = 3'd4;

  localparam logic [w-1:0] canonical_qnan = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};

  logic         v1_r, v2_r;
  logic [2:0]   op1_r;
  logic [w-1:0] a1_r, b1_r;
  logic [w-1:0] data2_r;
  logic         inv2_r;
  logic         sticky_r;

  logic en1, en2;

  // A stage may load when it is empty or its occupant is leaving this cycle.
  assign en2     = ~v2_r | yumi_i;
  assign en1     = ~v1_r | en2;
  assign ready_o = en1;

  // Operand fields and classification of the stage-1 operands.
  logic [e_p-1:0] exp_a, exp_b;
  logic [m_p-1:0] man_a, man_b;
  logic [w-2:0]   mag_a, mag_b;
  logic           sign_a, sign_b;
  logic           nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;
  logic           any_nan, both_zero;

  assign sign_a = a1_r[w-1];
  assign sign_b = b1_r[w-1];
  assign exp_a  = a1_r[w-2:m_p];
  assign exp_b  = b1_r[w-2:m_p];
  assign man_a  = a1_r[m_p-1:0];
  assign man_b  = b1_r[m_p-1:0];
  assign mag_a  = a1_r[w-2:0];
  assign mag_b  = b1_r[w-2:0];

  assign nan_a     = (&exp_a) & (|man_a);
  assign nan_b     = (&exp_b) & (|man_b);
  assign snan_a    = nan_a & ~man_a[m_p-1];
  assign snan_b    = nan_b & ~man_b[m_p-1];
  assign zero_a    = ~|mag_a;
  assign zero_b    = ~|mag_b;
  assign any_nan   = nan_a | nan_b;
  assign both_zero = zero_a & zero_b;

  logic lt_ord, lt_res, eq_res, le_res;

  // Sign first, then raw magnitude; two negatives order by descending magnitude.
  always_comb begin
    lt_ord = 1'b0;
    if (sign_a != sign_b)
      lt_ord = sign_a;
    else if (sign_a)
      lt_ord = (mag_a > mag_b);
    else
      lt_ord = (mag_a < mag_b);
  end

  assign lt_res = ~any_nan & ~both_zero & lt_ord;
  assign eq_res = ~any_nan & (both_zero | (a1_r == b1_r));
  assign le_res = lt_res | eq_res;

  logic [w-1:0] res_data;
  logic         res_inv;

  // Result and invalid flag selected by the operation code held in stage 1.
  always_comb begin
    res_data = '0;
    res_inv  = 1'b0;
    case (op1_r)
      op_eq: begin
        res_data = {{(w-1){1'b0}}, eq_res};
        res_inv  = snan_a | snan_b;
      end
      op_lt: begin
        res_data = {{(w-1){1'b0}}, lt_res};
        res_inv  = any_nan;
      end
      op_le: begin
        res_data = {{(w-1){1'b0}}, le_res};
        res_inv  = any_nan;
      end
      op_min, op_max: begin
        res_inv = snan_a | snan_b;
        if (nan_a & nan_b)
          res_data = canonical_qnan;
        else if (nan_a)
          res_data = b1_r;
        else if (nan_b)
          res_data = a1_r;
        else if (both_zero)
          res_data = (op1_r == op_min) ? {sign_a | sign_b, {(w-1){1'b0}}}
                                       : {sign_a & sign_b, {(w-1){1'b0}}};
        else if (op1_r == op_min)
          res_data = lt_res ? a1_r : b1_r;
        else
          res_data = lt_res ? b1_r : a1_r;
      end
      default: begin
        res_data = '0;
        res_inv  = 1'b0;
      end
    endcase
  end

  // Stage 1 captures the incoming op on a valid-ready handshake.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v1_r  <= 1'b0;
      op1_r <= '0;
      a1_r  <= '0;
      b1_r  <= '0;
    end else if (en1) begin
      v1_r <= v_i;
      if (v_i) begin
        op1_r <= op_i;
        a1_r  <= a_i;
        b1_r  <= b_i;
      end
    end
  end

  // Stage 2 registers the computed result and holds it until the consumer takes it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v2_r    <= 1'b0;
      data2_r <= '0;
      inv2_r  <= 1'b0;
    end else if (en2) begin
      v2_r <= v1_r;
      if (v1_r) begin
        data2_r <= res_data;
        inv2_r  <= res_inv;
      end
    end
  end

  // Sticky invalid flag: set by a consumed invalid result, which beats a simultaneous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      sticky_r <= 1'b0;
    else if (v2_r & yumi_i & inv2_r)
      sticky_r <= 1'b1;
    else if (clear_i)
      sticky_r <= 1'b0;
  end

  assign v_o              = v2_r;
  assign data_o           = data2_r;
  assign invalid_o        = inv2_r;
  assign invalid_sticky_o = sticky_r;

endmodule

// File: tb/tb_bsg_fpu_cmp_pipe.sv
// tb_bsg_fpu_cmp_pipe: directed scoreboard bench for a single-precision and a
// double-precision instance of bsg_fpu_cmp_pipe, driven one at a time.
module tb_bsg_fpu_cmp_pipe;

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
    logic        inv;
  } vec_t;

  typedef struct packed {
    logic [63:0] d;
    logic        inv;
    logic [31:0] acc;
  } sb_t;

  logic        clk;
  logic        reset_i;
  logic        dbl;
  logic        v_i, yumi_i, clear_i;
  logic [2:0]  op_i;
  logic [63:0] a_i, b_i;

  logic        ready_s, v_o_s, inv_s, sticky_s;
  logic [31:0] data_s;
  logic        ready_d, v_o_d, inv_d, sticky_d;
  logic [63:0] data_d;

  logic        v_i_s, yumi_s, clear_s;
  logic        v_i_d, yumi_d, clear_d;

  logic        ready_o, v_o, inv_o, sticky_o, yumi_eff;
  logic [63:0] data_o;

  int          errors;
  int          checks;
  logic [31:0] edge_cnt;
  logic        lat_mode;
  logic        yumi_pat_mode;
  logic [3:0]  yumi_pat;
  logic        accepted;
  logic [63:0] cur_d;
  logic        cur_inv;
  logic        exp_sticky [2];
  sb_t         sb [$];
  vec_t        tbl_s [$];
  vec_t        tbl_d [$];

  // The consumer only asserts yumi toward the selected instance while it shows a result.
  assign v_i_s   = v_i & ~dbl;
  assign yumi_s  = yumi_i & ~dbl & v_o_s;
  assign clear_s = clear_i & ~dbl;
  assign v_i_d   = v_i & dbl;
  assign yumi_d  = yumi_i & dbl & v_o_d;
  assign clear_d = clear_i & dbl;

  assign ready_o  = dbl ? ready_d  : ready_s;
  assign v_o      = dbl ? v_o_d    : v_o_s;
  assign inv_o    = dbl ? inv_d    : inv_s;
  assign sticky_o = dbl ? sticky_d : sticky_s;
  assign data_o   = dbl ? data_d   : {32'b0, data_s};
  assign yumi_eff = dbl ? yumi_d   : yumi_s;

  bsg_fpu_cmp_pipe #(.e_p(8), .m_p(23)) dut_s (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .v_i              (v_i_s),
    .ready_o          (ready_s),
    .op_i             (op_i),
    .a_i              (a_i[31:0]),
    .b_i              (b_i[31:0]),
    .v_o              (v_o_s),
    .yumi_i           (yumi_s),
    .data_o           (data_s),
    .invalid_o        (inv_s),
    .invalid_sticky_o (sticky_s),
    .clear_i          (clear_s)
  );

  bsg_fpu_cmp_pipe #(.e_p(11), .m_p(52)) dut_d (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .v_i              (v_i_d),
    .ready_o          (ready_d),
    .op_i             (op_i),
    .a_i              (a_i),
    .b_i              (b_i),
    .v_o              (v_o_d),
    .yumi_i           (yumi_d),
    .data_o           (data_d),
    .invalid_o        (inv_d),
    .invalid_sticky_o (sticky_d),
    .clear_i          (clear_d)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs despite the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] d, input logic inv);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.d = d; v.inv = inv;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One clock cycle: sample at the falling edge, score handshakes, advance past the rising edge.
  task automatic cycle();
    sb_t  e;
    logic nxt;
    if (yumi_pat_mode) yumi_i = yumi_pat[edge_cnt % 4];
    @(negedge clk);
    checkOutput("ready_o", 64'(ready_o), 64'(!((sb.size() == 2) && !yumi_eff)));
    checkOutput("sticky", 64'(sticky_o), 64'(exp_sticky[dbl]));
    nxt = exp_sticky[dbl] & ~clear_i;
    if (v_o && (sb.size() == 0))
      checkOutput("stale_result", 64'(v_o), 64'd0);
    if (v_o && yumi_eff && (sb.size() != 0)) begin
      e = sb.pop_front();
      checkOutput("data_o", data_o, e.d);
      checkOutput("invalid_o", 64'(inv_o), 64'(e.inv));
      if (lat_mode) checkOutput("latency", 64'(edge_cnt + 32'd1 - e.acc), 64'd2);
      if (e.inv) nxt = 1'b1;
    end
    if (v_i && ready_o) begin
      e.d = cur_d; e.inv = cur_inv; e.acc = edge_cnt + 32'd1;
      sb.push_back(e);
      accepted = 1'b1;
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    exp_sticky[dbl] = nxt;
  endtask

  // Present one op and hold it until the unit accepts it.
  task automatic applyStimulus(input vec_t v);
    v_i = 1'b1; op_i = v.op; a_i = v.a; b_i = v.b;
    cur_d = v.d; cur_inv = v.inv;
    accepted = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) cycle();
    checkOutput("accept", 64'(accepted), 64'd1);
    v_i = 1'b0;
  endtask

  task automatic drain();
    v_i = 1'b0; yumi_pat_mode = 1'b0; yumi_i = 1'b1;
    for (int k = 0; k < 30 && sb.size() != 0; k++) cycle();
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    cycle();
  endtask

  task automatic checkResetState();
    checkOutput("rst_v_o_s", 64'(v_o_s), 64'd0);
    checkOutput("rst_data_s", 64'(data_s), 64'd0);
    checkOutput("rst_inv_s", 64'(inv_s), 64'd0);
    checkOutput("rst_sticky_s", 64'(sticky_s), 64'd0);
    checkOutput("rst_v_o_d", 64'(v_o_d), 64'd0);
    checkOutput("rst_data_d", data_d, 64'd0);
    checkOutput("rst_inv_d", 64'(inv_d), 64'd0);
    checkOutput("rst_sticky_d", 64'(sticky_d), 64'd0);
  endtask

  initial begin
    errors = 0; checks = 0; edge_cnt = 0;
    lat_mode = 1'b0; yumi_pat_mode = 1'b0; yumi_pat = 4'b1001;
    exp_sticky[0] = 1'b0; exp_sticky[1] = 1'b0;
    reset_i = 1'b1; dbl = 1'b0; v_i = 1'b0; yumi_i = 1'b0; clear_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; cur_d = '0; cur_inv = 1'b0; accepted = 1'b0;

    tbl_s.push_back(mk(3'd1, 64'hBF800000, 64'h3F800000, 64'd1, 1'b0));
    tbl_s.push_back(mk(3'd2, 64'h80000000, 64'h00000000, 64'd1, 1'b0));
    tbl_s.push_back(mk(3'd0, 64'h80000000, 64'h00000000, 64'd1, 1'b0));
    tbl_s.push_back(mk(3'd0, 64'h7FC00000, 64'h00000000, 64'd0, 1'b0));
    tbl_s.push_back(mk(3'd0, 64'h7F800001, 64'h00000000, 64'd0, 1'b1));
    tbl_s.push_back(mk(3'd1, 64'h7FC00000, 64'h00000000, 64'd0, 1'b1));
    tbl_s.push_back(mk(3'd3, 64'h7F800001, 64'h40000000, 64'h40000000, 1'b1));
    tbl_s.push_back(mk(3'd4, 64'h7FC00001, 64'h7FC00001, 64'h7FC00000, 1'b0));
    tbl_s.push_back(mk(3'd3, 64'h00000000, 64'h80000000, 64'h80000000, 1'b0));
    tbl_s.push_back(mk(3'd4, 64'h00000000, 64'h80000000, 64'h00000000, 1'b0));
    tbl_s.push_back(mk(3'd3, 64'hC0000000, 64'hBF800000, 64'hC0000000, 1'b0));
    tbl_s.push_back(mk(3'd5, 64'h3F800000, 64'h00000000, 64'd0, 1'b0));
    tbl_s.push_back(mk(3'd1, 64'h80000000, 64'h00000000, 64'd0, 1'b0));
    tbl_s.push_back(mk(3'd4, 64'h3F800000, 64'h40000000, 64'h40000000, 1'b0));
    tbl_s.push_back(mk(3'd2, 64'hC0000000, 64'hBF800000, 64'd1, 1'b0));
    tbl_s.push_back(mk(3'd1, 64'h3F800000, 64'hBF800000, 64'd0, 1'b0));

    tbl_d.push_back(mk(3'd1, 64'hBFF0000000000000, 64'h3FF0000000000000, 64'd1, 1'b0));
    tbl_d.push_back(mk(3'd2, 64'h8000000000000000, 64'h0000000000000000, 64'd1, 1'b0));
    tbl_d.push_back(mk(3'd0, 64'h8000000000000000, 64'h0000000000000000, 64'd1, 1'b0));
    tbl_d.push_back(mk(3'd0, 64'h7FF8000000000000, 64'h0000000000000000, 64'd0, 1'b0));
    tbl_d.push_back(mk(3'd0, 64'h7FF0000000000001, 64'h0000000000000000, 64'd0, 1'b1));
    tbl_d.push_back(mk(3'd1, 64'h7FF8000000000000, 64'h0000000000000000, 64'd0, 1'b1));
    tbl_d.push_back(mk(3'd3, 64'h7FF0000000000001, 64'h4000000000000000, 64'h4000000000000000, 1'b1));
    tbl_d.push_back(mk(3'd4, 64'h7FF8000000000001, 64'h7FF8000000000001, 64'h7FF8000000000000, 1'b0));
    tbl_d.push_back(mk(3'd3, 64'h0000000000000000, 64'h8000000000000000, 64'h8000000000000000, 1'b0));
    tbl_d.push_back(mk(3'd4, 64'h0000000000000000, 64'h8000000000000000, 64'h0000000000000000, 1'b0));
    tbl_d.push_back(mk(3'd3, 64'hC000000000000000, 64'hBFF0000000000000, 64'hC000000000000000, 1'b0));
    tbl_d.push_back(mk(3'd5, 64'h3FF0000000000000, 64'h0000000000000000, 64'd0, 1'b0));
    tbl_d.push_back(mk(3'd1, 64'h8000000000000000, 64'h0000000000000000, 64'd0, 1'b0));
    tbl_d.push_back(mk(3'd4, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000000, 1'b0));
    tbl_d.push_back(mk(3'd2, 64'hC000000000000000, 64'hBFF0000000000000, 64'd1, 1'b0));
    tbl_d.push_back(mk(3'd1, 64'h3FF0000000000000, 64'hBFF0000000000000, 64'd0, 1'b0));

    // Power-on reset, then release between edges.
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    checkOutput("rst_ready_s", 64'(ready_s), 64'd1);
    checkOutput("rst_ready_d", 64'(ready_d), 64'd1);
    reset_i = 1'b0;

    for (int cfg = 0; cfg < 2; cfg++) begin
      vec_t tbl [$];
      dbl = cfg[0];
      tbl = cfg ? tbl_d : tbl_s;
      $display("[TB] configuration %0s", cfg ? "e_p=11 m_p=52" : "e_p=8 m_p=23");

      // Full throughput: every result appears two edges after its accept.
      lat_mode = 1'b1; yumi_i = 1'b1;
      foreach (tbl[i]) applyStimulus(tbl[i]);
      drain();
      lat_mode = 1'b0;

      // Back-pressure with yumi following 1,0,0,1 against 8 back-to-back ops.
      yumi_pat_mode = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);
      drain();

      // Sticky flag: unconsumed does not set, set beats clear, clear alone clears.
      yumi_i = 1'b0; clear_i = 1'b1;
      cycle();
      clear_i = 1'b0;
      applyStimulus(tbl[4]);
      cycle();
      checkOutput("v_o_held", 64'(v_o), 64'd1);
      checkOutput("sticky_unconsumed", 64'(sticky_o), 64'd0);
      yumi_i = 1'b1; clear_i = 1'b1;
      cycle();
      checkOutput("sticky_set_wins", 64'(sticky_o), 64'd1);
      yumi_i = 1'b0; clear_i = 1'b1;
      cycle();
      checkOutput("sticky_cleared", 64'(sticky_o), 64'd0);
      clear_i = 1'b0;
      yumi_i = 1'b1;
      applyStimulus(tbl[4]);
      drain();
      checkOutput("sticky_reset_pre", 64'(sticky_o), 64'd1);
    end

    // Reset mid-stream with two ops buffered and the consumer stalled.
    dbl = 1'b0; yumi_i = 1'b0;
    applyStimulus(tbl_s[13]);
    applyStimulus(tbl_s[0]);
    checkOutput("ready_full", 64'(ready_o), 64'd0);
    reset_i = 1'b1;
    #1;
    checkResetState();
    sb.delete();
    exp_sticky[0] = 1'b0; exp_sticky[1] = 1'b0;
    #1;
    reset_i = 1'b0;
    #1;
    checkOutput("ready_after_reset", 64'(ready_o), 64'd1);
    yumi_i = 1'b1;
    repeat (4) cycle();
    checkOutput("no_stale_v_o", 64'(v_o), 64'd0);

    // Life after reset: one more op flows through normally.
    applyStimulus(tbl_s[10]);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
